// File: rtl/ps2_kbd_pkg.sv
// Shared constants for the PS/2 Scan Code Set 2 decoder: FSM encoding, prefix bytes,
// ignored controller replies, game-key codes and the bitmap indices the game FSM uses.
package ps2_kbd_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_EXT     = 3'd1;
    localparam logic [2:0] ST_BRK     = 3'd2;
    localparam logic [2:0] ST_EXT_BRK = 3'd3;
    localparam logic [2:0] ST_SKIP    = 3'd4;

    localparam logic [7:0] PFX_E0     = 8'hE0;
    localparam logic [7:0] PFX_F0     = 8'hF0;
    localparam logic [7:0] PFX_E1     = 8'hE1;
    localparam logic [7:0] FAKE_SHIFT = 8'h12;

    // Pause is E1 followed by seven more bytes that carry no usable key information.
    localparam logic [2:0] PAUSE_TAIL = 3'd7;

    localparam logic [7:0] IGN_BAT_OK = 8'hAA;
    localparam logic [7:0] IGN_ACK    = 8'hFA;
    localparam logic [7:0] IGN_ECHO   = 8'hEE;
    localparam logic [7:0] IGN_RESEND = 8'hFE;
    localparam logic [7:0] IGN_ERR0   = 8'h00;
    localparam logic [7:0] IGN_ERR1   = 8'hFF;

    localparam logic [7:0] CODE_UP    = 8'h75;
    localparam logic [7:0] CODE_DOWN  = 8'h72;
    localparam logic [7:0] CODE_LEFT  = 8'h6B;
    localparam logic [7:0] CODE_RIGHT = 8'h74;
    localparam logic [7:0] CODE_Z     = 8'h1A;
    localparam logic [7:0] CODE_X     = 8'h22;
    localparam logic [7:0] CODE_ENTER = 8'h5A;
    localparam logic [7:0] CODE_ESC   = 8'h76;

    localparam logic [2:0] KEY_UP    = 3'd0;
    localparam logic [2:0] KEY_DOWN  = 3'd1;
    localparam logic [2:0] KEY_LEFT  = 3'd2;
    localparam logic [2:0] KEY_RIGHT = 3'd3;
    localparam logic [2:0] KEY_Z     = 3'd4;
    localparam logic [2:0] KEY_X     = 3'd5;
    localparam logic [2:0] KEY_ENTER = 3'd6;
    localparam logic [2:0] KEY_ESC   = 3'd7;

    typedef struct packed {
        logic       ext;
        logic [7:0] code;
    } key_id_t;

    function automatic logic is_ignored(input logic [7:0] b);
        return b inside {IGN_BAT_OK, IGN_ACK, IGN_ECHO, IGN_RESEND, IGN_ERR0, IGN_ERR1};
    endfunction

endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// Byte stream from the PS/2 receive controller and decoded key events toward the game FSM.
// master = byte producer / event consumer, slave = the decoder.
interface ps2_scancode_decoder_if;

    logic [7:0] received_data;
    logic       received_data_en;
    logic       key_event;
    logic [7:0] key_code;
    logic       key_extended;
    logic       key_break;
    logic [7:0] keys_held;
    logic [7:0] keys_pressed;

    modport master (
        output received_data,
        output received_data_en,
        input  key_event,
        input  key_code,
        input  key_extended,
        input  key_break,
        input  keys_held,
        input  keys_pressed
    );

    modport slave (
        input  received_data,
        input  received_data_en,
        output key_event,
        output key_code,
        output key_extended,
        output key_break,
        output keys_held,
        output keys_pressed
    );

endinterface

// File: rtl/ps2_key_map.sv
// Combinational lookup from {extended, scan code} to a game-key bitmap index.
// Kept apart from the decoder so the key set can change without touching the FSM.
module ps2_key_map
    import ps2_kbd_pkg::*;
(
    input  key_id_t    i_key,
    output logic       o_hit,
    output logic [2:0] o_idx
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        o_hit = 1'b0;
        o_idx = 3'd0;
        case (i_key)
            {1'b1, CODE_UP}: begin
                o_hit = 1'b1;
                o_idx = KEY_UP;
            end
            {1'b1, CODE_DOWN}: begin
                o_hit = 1'b1;
                o_idx = KEY_DOWN;
            end
            {1'b1, CODE_LEFT}: begin
                o_hit = 1'b1;
                o_idx = KEY_LEFT;
            end
            {1'b1, CODE_RIGHT}: begin
                o_hit = 1'b1;
                o_idx = KEY_RIGHT;
            end
            {1'b0, CODE_Z}: begin
                o_hit = 1'b1;
                o_idx = KEY_Z;
            end
            {1'b0, CODE_X}: begin
                o_hit = 1'b1;
                o_idx = KEY_X;
            end
            {1'b0, CODE_ENTER}: begin
                o_hit = 1'b1;
                o_idx = KEY_ENTER;
            end
            {1'b0, CODE_ESC}: begin
                o_hit = 1'b1;
                o_idx = KEY_ESC;
            end
            default: begin
                o_hit = 1'b0;
                o_idx = 3'd0;
            end
        endcase
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Scan Code Set 2 decoder: turns the PS/2 byte stream into make/break events, tracks the
// eight game keys as a held bitmap and pulses keys_pressed on each fresh press.
module ps2_scancode_decoder
    import ps2_kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    ps2_scancode_decoder_if.slave bus
);

    localparam int              TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]      r_state;
    logic [2:0]      r_skip_cnt;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_key_event;
    logic [7:0]      r_key_code;
    logic            r_key_ext;
    logic            r_key_brk;
    logic [7:0]      r_held;
    logic [7:0]      r_pressed;

    logic [7:0]      w_byte;
    logic            w_strobe;
    logic            w_timeout;
    logic [2:0]      w_next_state;
    logic [2:0]      w_next_skip;
    logic            w_evt;
    logic            w_evt_ext;
    logic            w_evt_brk;
    key_id_t         w_map_key;
    logic            w_map_hit;
    logic [2:0]      w_map_idx;
    logic [7:0]      w_held_next;

    assign w_byte    = bus.received_data;
    assign w_strobe  = bus.received_data_en;
    assign w_timeout = (r_state != ST_IDLE) && (r_to_cnt == TO_LAST);

    always_comb begin
        w_next_state = r_state;
        w_next_skip  = r_skip_cnt;
        w_evt        = 1'b0;
        w_evt_ext    = 1'b0;
        w_evt_brk    = 1'b0;
        if (w_strobe) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_byte == PFX_E0) begin
                        w_next_state = ST_EXT;
                    end else if (w_byte == PFX_F0) begin
                        w_next_state = ST_BRK;
                    end else if (w_byte == PFX_E1) begin
                        w_next_state = ST_SKIP;
                        w_next_skip  = PAUSE_TAIL;
                    end else if (!is_ignored(w_byte)) begin
                        w_evt = 1'b1;
                    end
                end
                ST_EXT: begin
                    // A repeated E0 or the PrtScn fake shift keeps waiting for the real code.
                    if (w_byte == PFX_F0) begin
                        w_next_state = ST_EXT_BRK;
                    end else if (w_byte != PFX_E0 && w_byte != FAKE_SHIFT) begin
                        w_evt        = 1'b1;
                        w_evt_ext    = 1'b1;
                        w_next_state = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    w_evt        = 1'b1;
                    w_evt_brk    = 1'b1;
                    w_next_state = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    w_evt        = 1'b1;
                    w_evt_ext    = 1'b1;
                    w_evt_brk    = 1'b1;
                    w_next_state = ST_IDLE;
                end
                ST_SKIP: begin
                    if (r_skip_cnt <= 3'd1) begin
                        w_next_skip  = 3'd0;
                        w_next_state = ST_IDLE;
                    end else begin
                        w_next_skip = r_skip_cnt - 3'd1;
                    end
                end
                default: begin
                    w_next_skip  = 3'd0;
                    w_next_state = ST_IDLE;
                end
            endcase
        end else if (w_timeout) begin
            w_next_skip  = 3'd0;
            w_next_state = ST_IDLE;
        end
    end

    assign w_map_key.ext  = w_evt_ext;
    assign w_map_key.code = w_byte;

    ps2_key_map u_key_map (
        .i_key (w_map_key),
        .o_hit (w_map_hit),
        .o_idx (w_map_idx)
    );

    always_comb begin
        w_held_next = r_held;
        if (w_evt && w_map_hit) begin
            w_held_next[w_map_idx] = !w_evt_brk;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_skip_cnt <= 3'd0;
            r_to_cnt   <= '0;
        end else begin
            // NOTE: sequential state uses <= so every register sees the pre-edge values.
            r_state    <= w_next_state;
            r_skip_cnt <= w_next_skip;
            if (r_state == ST_IDLE || w_strobe || w_timeout) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt != TO_LAST) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_key_event <= 1'b0;
            r_key_code  <= 8'h00;
            r_key_ext   <= 1'b0;
            r_key_brk   <= 1'b0;
            r_held      <= 8'h00;
            r_pressed   <= 8'h00;
        end else begin
            r_key_event <= w_evt;
            if (w_evt) begin
                r_key_code <= w_byte;
                r_key_ext  <= w_evt_ext;
                r_key_brk  <= w_evt_brk;
            end
            r_held    <= w_held_next;
            r_pressed <= w_held_next & ~r_held;
        end
    end

    assign bus.key_event    = r_key_event;
    assign bus.key_code     = r_key_code;
    assign bus.key_extended = r_key_ext;
    assign bus.key_break    = r_key_brk;
    assign bus.keys_held    = r_held;
    assign bus.keys_pressed = r_pressed;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Scoreboard bench for ps2_scancode_decoder: expected events are queued as bytes are sent
// and compared whenever the decoder pulses key_event.
module tb_ps2_scancode_decoder;

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [7:0] held;
        logic [7:0] pressed;
    } exp_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    exp_t sb_q[$];

    ps2_scancode_decoder_if bus ();

    ps2_scancode_decoder #(
        .TIMEOUT_CYCLES (16)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Event monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.key_event === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_event", {31'd0, bus.key_event}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("key_code",     {24'd0, bus.key_code},     {24'd0, e.code});
                    check("key_extended", {31'd0, bus.key_extended}, {31'd0, e.ext});
                    check("key_break",    {31'd0, bus.key_break},    {31'd0, e.brk});
                    check("keys_held",    {24'd0, bus.keys_held},    {24'd0, e.held});
                    check("keys_pressed", {24'd0, bus.keys_pressed}, {24'd0, e.pressed});
                end
            end else if (bus.keys_pressed !== 8'h00) begin
                check("stray_pressed", {24'd0, bus.keys_pressed}, 32'd0);
            end
        end
    end

    task automatic expect_evt(input logic [7:0] code, input logic ext, input logic brk,
                              input logic [7:0] held, input logic [7:0] pressed);
        exp_t e;
        e.code    = code;
        e.ext     = ext;
        e.brk     = brk;
        e.held    = held;
        e.pressed = pressed;
        sb_q.push_back(e);
    endtask

    // One strobe, then one quiet cycle; returns #1 after a rising edge.
    task automatic send(input logic [7:0] b);
        bus.received_data    = b;
        bus.received_data_en = 1'b1;
        @(posedge clk);
        #1;
        bus.received_data_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        idle(3);
        check(tag, sb_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pause_seq [8];
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.received_data    = 8'h00;
        bus.received_data_en = 1'b0;
        idle(3);
        rst = 1'b0;

        check("rst_key_event", {31'd0, bus.key_event},    32'd0);
        check("rst_key_code",  {24'd0, bus.key_code},     32'd0);
        check("rst_key_ext",   {31'd0, bus.key_extended}, 32'd0);
        check("rst_key_break", {31'd0, bus.key_break},    32'd0);
        check("rst_held",      {24'd0, bus.keys_held},    32'd0);
        check("rst_pressed",   {24'd0, bus.keys_pressed}, 32'd0);

        // Z make, then typematic repeats without new press pulses
        expect_evt(8'h1A, 1'b0, 1'b0, 8'h10, 8'h10);
        send(8'h1A);
        for (int i = 0; i < 3; i++) begin
            expect_evt(8'h1A, 1'b0, 1'b0, 8'h10, 8'h00);
            send(8'h1A);
        end
        drain("q_z_make");

        // Up arrow make then break
        send(8'hE0);
        expect_evt(8'h75, 1'b1, 1'b0, 8'h11, 8'h01);
        send(8'h75);
        send(8'hE0);
        send(8'hF0);
        expect_evt(8'h75, 1'b1, 1'b1, 8'h10, 8'h00);
        send(8'h75);
        drain("q_up");

        // Pause sequence is swallowed, X then decodes normally
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        for (int i = 0; i < 8; i++) send(pause_seq[i]);
        expect_evt(8'h22, 1'b0, 1'b0, 8'h30, 8'h20);
        send(8'h22);
        drain("q_pause");

        // Break of an unheld mapped key, then Left behind a PrtScn fake shift
        send(8'hE0);
        send(8'hF0);
        expect_evt(8'h74, 1'b1, 1'b1, 8'h30, 8'h00);
        send(8'h74);
        send(8'hE0);
        send(8'h12);
        send(8'hE0);
        expect_evt(8'h6B, 1'b1, 1'b0, 8'h34, 8'h04);
        send(8'h6B);
        drain("q_ext_misc");

        // E0 then 16 quiet cycles: prefix dropped, 75 is a plain unmapped make
        send(8'hE0);
        idle(15);
        expect_evt(8'h75, 1'b0, 1'b0, 8'h34, 8'h00);
        send(8'h75);
        drain("q_timeout");

        // Esc make, then F0 with the 76 strobe landing on the expiry cycle
        expect_evt(8'h76, 1'b0, 1'b0, 8'hB4, 8'h80);
        send(8'h76);
        send(8'hF0);
        idle(14);
        expect_evt(8'h76, 1'b0, 1'b1, 8'h34, 8'h00);
        send(8'h76);
        drain("q_expiry_strobe");

        // Ignored bytes, then reset after a dangling F0
        send(8'hAA);
        send(8'hFA);
        send(8'hF0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("mid_rst_held", {24'd0, bus.keys_held}, 32'd0);
        check("mid_rst_code", {24'd0, bus.key_code},  32'd0);
        expect_evt(8'h5A, 1'b0, 1'b0, 8'h40, 8'h40);
        send(8'h5A);
        drain("q_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
